rv0_ahb_mem_sub: RTL and testbench
==================================

# rv0_ahb_mem_sub

AHB-Lite subordinate that answers the transfers issued by the rv0 core's AHB manager port, backed by an internal register-array memory. It decodes the address phase and inserts a configurable number of wait states. Byte, halfword and word accesses are served with OKAY, and illegal accesses are answered with the two-cycle ERROR response. It sits on the instruction/data bus as the boot/scratch memory, or as the bench's reference responder.

## Interface
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; 32 or 64 only.
- MEM_BASE, 'h0010_0000, first byte address served; aligned to MEM_SIZE.
- MEM_SIZE, 4096, bytes of storage; power of two, ≥ DATA_WIDTH/8.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; 0..15.
- clk  in  1  bus clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hsel  in  1  subordinate select, address phase.
- haddr  in  ADDR_WIDTH  byte address, address phase.
- htrans  in  2  ahb_uvc_htrans_e: IDLE/BUSY/NONSEQ/SEQ.
- hsize  in  3  ahb_uvc_hsize_e.
- hburst  in  3  ahb_uvc_hburst_e; accepted and ignored. Every beat is decoded independently.
- hwrite  in  1  1 = write.
- hwdata  in  DATA_WIDTH  write data, data phase.
- hready  in  1  bus-wide ready; a transfer is sampled only when high.
- hreadyout  out  1  this subordinate's data-phase ready.
- hresp  out  1  ahb_uvc_hresp_e: OKAY=0, ERROR=1.
- hrdata  out  DATA_WIDTH  read data, valid when hreadyout=1 in a read data phase.

## Operation
- Accept when hsel & hready & htrans ∈ {NONSEQ, SEQ}. Register haddr, hsize and hwrite, and evaluate the error check.
- IDLE/BUSY, or an unselected cycle with hready=1: the next data phase is zero-wait OKAY, with no memory access.
- Error when any of the following holds:
  - haddr < MEM_BASE or haddr ≥ MEM_BASE+MEM_SIZE;
  - 2^hsize > DATA_WIDTH/8;
  - haddr mod 2^hsize ≠ 0.
- An errored transfer never writes memory. hrdata=0 throughout it.
- Lane mask: 2^hsize consecutive bytes starting at lane haddr[log2(DATA_WIDTH/8)-1:0]. Write data is taken from the matching hwdata lanes (AHB little-endian lane placement).
- Reads return the full aligned memory word on hrdata; the manager extracts the lanes.
- Writes commit at the rising edge that ends the data phase (hreadyout=1). A read in the immediately following data phase observes the new data, so there is no forwarding hazard.
- FSM states:
  - IDLE: hreadyout=1, hresp=OKAY.
    - Accepted OKAY transfer with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
    - Accepted OKAY transfer with WAIT_STATES=0 → DATA.
    - Error → ERR1.
  - WAIT: hreadyout=0, hresp=OKAY. Counter decrements; at 0 → DATA.
  - DATA: hreadyout=1, hresp=OKAY, read data driven, write committed at end. Then:
    - new accept → WAIT, DATA or ERR1, per the IDLE rules;
    - no accept → IDLE.
  - ERR1: hreadyout=0, hresp=ERROR → ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. Address phase sampled as in DATA; → WAIT, DATA, ERR1 or IDLE.
- The address phase is sampled only in IDLE, DATA and ERR2, i.e. when hready=1. In WAIT and ERR1, hreadyout=0 holds the bus.
- The manager may change htrans to IDLE during ERR1. This has no effect; ERR2 still follows.

## Timing
- Reset (async assert, sync release): state IDLE, hreadyout=1, hresp=OKAY, hrdata=0, counter=0. A pending write is discarded. Memory contents are not reset (X until written).
- Reset asserted mid-WAIT or mid-ERR1: outputs return to reset values immediately; no partial write.
- OKAY transfer latency: data phase = 1+WAIT_STATES cycles. Back-to-back pipelined transfers sustain 1 beat per 1+WAIT_STATES cycles.
- ERROR: always exactly 2 cycles, independent of WAIT_STATES.
- hrdata is registered alongside the state. It equals the memory word only in the final read data-phase cycle and is 0 in all other cycles.
- hresp, hreadyout and hrdata are driven from flops; none is combinational from bus inputs.

## Test plan
- WAIT_STATES=0: NONSEQ write word 0xDEADBEEF to 0x0010_0000, then NONSEQ read of the same address back-to-back → read data phase hreadyout=1, hrdata=0xDEADBEEF, hresp=OKAY, no stall cycles.
- Byte/halfword lanes: SB 0xAA to 0x0010_0005, then SH 0x1234 to 0x0010_0006 → word read at 0x0010_0004 returns 0x1234AAxx, with byte 0 unchanged from its previous write.
- Errors, each with hsel=1:
  - read at 0x0010_1000 (out of range) → hreadyout 0 then 1 with hresp=ERROR both cycles, hrdata=0;
  - SW to 0x0010_0002 (misaligned) → the same two-cycle ERROR; a subsequent read at 0x0010_0000 shows memory unchanged.
- WAIT_STATES=3: pipelined 4-beat INCR4 read with a BUSY inserted after beat 2 → each beat holds hreadyout=0 for exactly 3 cycles. BUSY gets a zero-wait OKAY, data is correct per beat, hburst is ignored.
- Reset mid-operation: assert rst_n=0 during the 2nd WAIT cycle of a write to 0x0010_0010 → hreadyout=1, hresp=0 and hrdata=0 asynchronously; after release, a read of 0x0010_0010 shows the old value, not the write data.
- Unselected/idle: hsel=0 with htrans=NONSEQ, or hsel=1 with htrans=IDLE, for 10 cycles → hreadyout stays 1, hresp=OKAY, no memory change.

Source files
------------

// File: rtl/rv0_ahb_mem_sub_if.sv
// AHB-Lite bus bundle between a manager and the rv0 memory subordinate.
interface rv0_ahb_mem_sub_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic                  hwrite;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/rv0_ahb_mem_sub.sv
// AHB-Lite memory subordinate: register-array storage, configurable wait
// states, two-cycle ERROR for out-of-range, oversize or misaligned beats.
module rv0_ahb_mem_sub #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE    = 32'h0010_0000,
  parameter int                    MEM_SIZE    = 4096,
  parameter int                    WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rv0_ahb_mem_sub_if.slave   bus
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int OFF_W  = $clog2(MEM_SIZE);
  localparam int IDX_W  = OFF_W - LANE_W;
  localparam int DEPTH  = MEM_SIZE / NB;
  localparam logic [ADDR_WIDTH-OFF_W-1:0] BASE_HI = MEM_BASE[ADDR_WIDTH-1:OFF_W];
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Out of window, wider than the data bus, or not naturally aligned.
  function automatic logic xfer_error(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [2:0] size);
    logic err;
    err = (addr[ADDR_WIDTH-1:OFF_W] != BASE_HI);
    err = err | (int'(size) > LANE_W);
    for (int i = 0; i < 7; i++) begin
      err = err | ((i < int'(size)) ? addr[i] : 1'b0);
    end
    return err;
  endfunction

  // 2^size consecutive byte lanes starting at the beat's lane offset.
  function automatic logic [NB-1:0] lane_mask(input logic [LANE_W-1:0] lane,
                                              input logic [2:0] size);
    logic [NB-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      m[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << int'(size)));
    end
    return m;
  endfunction

  state_e                state_r;
  logic [3:0]            cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [LANE_W-1:0]     lane_r;
  logic [2:0]            size_r;
  logic                  write_r;
  logic                  hreadyout_r;
  logic                  hresp_r;
  logic [DATA_WIDTH-1:0] hrdata_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  sample_s;
  logic                  accept_s;
  logic                  err_s;
  logic                  wr_en_s;
  logic [NB-1:0]         wr_mask_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  unused_s;

  assign sample_s  = (state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2);
  assign accept_s  = sample_s & bus.hsel & bus.hready & bus.htrans[1];
  assign err_s     = xfer_error(bus.haddr, bus.hsize);
  assign wr_en_s   = (state_r == ST_DATA) & write_r & rst_n;
  assign wr_mask_s = lane_mask(lane_r, size_r);
  assign rd_idx_s  = (state_r == ST_WAIT) ? idx_r : bus.haddr[OFF_W-1:LANE_W];
  assign unused_s  = ^{bus.hburst, bus.htrans[0]};

  // Read word for the next data phase, with the write retiring this cycle merged in.
  always_comb begin
    rd_word_s = mem_r[rd_idx_s];
    for (int b = 0; b < NB; b++) begin
      rd_word_s[8*b +: 8] = (wr_en_s && wr_mask_s[b] && (idx_r == rd_idx_s))
                            ? bus.hwdata[8*b +: 8] : rd_word_s[8*b +: 8];
    end
  end

  // Storage: byte-lane write at the edge that closes a write data phase.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_mask_s[b]) begin
          mem_r[idx_r][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
    end
  end

  // Transfer FSM with registered bus responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      idx_r       <= '0;
      lane_r      <= '0;
      size_r      <= 3'd0;
      write_r     <= 1'b0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      hrdata_r    <= '0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= ST_DATA;
            hreadyout_r <= 1'b1;
            hrdata_r    <= write_r ? '0 : rd_word_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ERR1: begin
          state_r     <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept_s) begin
            idx_r   <= bus.haddr[OFF_W-1:LANE_W];
            lane_r  <= bus.haddr[LANE_W-1:0];
            size_r  <= bus.hsize;
            write_r <= bus.hwrite;
            if (err_s) begin
              state_r     <= ST_ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b1;
              hrdata_r    <= '0;
            end else if (WAIT_STATES > 0) begin
              state_r     <= ST_WAIT;
              cnt_r       <= WS_LOAD;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b0;
              hrdata_r    <= '0;
            end else begin
              state_r     <= ST_DATA;
              hreadyout_r <= 1'b1;
              hresp_r     <= 1'b0;
              hrdata_r    <= bus.hwrite ? '0 : rd_word_s;
            end
          end else begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= '0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
          hrdata_r    <= '0;
        end
      endcase
    end
  end

  assign bus.hreadyout = hreadyout_r;
  assign bus.hresp     = hresp_r;
  assign bus.hrdata    = hrdata_r;

endmodule

// File: tb/tb_rv0_ahb_mem_sub.sv
// Directed bench: one zero-wait and one three-wait subordinate share the
// manager stimulus; sel_v picks which one is addressed and drives hready.
module tb_rv0_ahb_mem_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_v;
  logic        hsel_v;
  logic [31:0] haddr_v;
  logic [1:0]  htrans_v;
  logic [2:0]  hsize_v;
  logic [2:0]  hburst_v;
  logic        hwrite_v;
  logic [31:0] hwdata_v;
  logic        hreadyout_s;
  logic        hresp_s;
  logic [31:0] hrdata_s;

  int n_checks = 0;
  int n_pass   = 0;
  int waits;
  logic [31:0] rd;
  logic        resp;
  int p, dp, stall, done;

  logic [1:0]  ph_t  [5] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11};
  logic [31:0] ph_a  [5] = '{32'h0010_0000, 32'h0010_0004, 32'h0010_0008,
                             32'h0010_0008, 32'h0010_000C};
  logic [31:0] exp_d [5] = '{32'hA000_0000, 32'hA000_0001, 32'h0000_0000,
                             32'hA000_0002, 32'hA000_0003};
  int          exp_st[5] = '{3, 3, 0, 3, 3};

  always #5 clk = ~clk;

  rv0_ahb_mem_sub_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  rv0_ahb_mem_sub_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  assign bus0.hsel   = hsel_v & ~sel_v;
  assign bus3.hsel   = hsel_v & sel_v;
  assign bus0.haddr  = haddr_v;   assign bus3.haddr  = haddr_v;
  assign bus0.htrans = htrans_v;  assign bus3.htrans = htrans_v;
  assign bus0.hsize  = hsize_v;   assign bus3.hsize  = hsize_v;
  assign bus0.hburst = hburst_v;  assign bus3.hburst = hburst_v;
  assign bus0.hwrite = hwrite_v;  assign bus3.hwrite = hwrite_v;
  assign bus0.hwdata = hwdata_v;  assign bus3.hwdata = hwdata_v;
  assign hreadyout_s = sel_v ? bus3.hreadyout : bus0.hreadyout;
  assign hresp_s     = sel_v ? bus3.hresp     : bus0.hresp;
  assign hrdata_s    = sel_v ? bus3.hrdata    : bus0.hrdata;
  assign bus0.hready = hreadyout_s;
  assign bus3.hready = hreadyout_s;

  rv0_ahb_mem_sub #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rv0_ahb_mem_sub #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input logic s, input logic [1:0] t, input logic w,
                         input logic [31:0] a, input logic [2:0] sz);
    hsel_v = s; htrans_v = t; hwrite_v = w; haddr_v = a; hsize_v = sz;
  endtask

  task automatic idle_ph();
    addr_ph(1'b0, 2'b00, 1'b0, 32'h0, 3'd2);
  endtask

  // One non-pipelined NONSEQ transfer; reports read data, stall cycles and final hresp.
  task automatic single(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rdo,
                        output int wt, output logic rsp);
    addr_ph(1'b1, 2'b10, w, a, sz);
    step();
    idle_ph();
    hwdata_v = wd;
    wt = 0;
    while (hreadyout_s !== 1'b1 && wt < 40) begin
      wt++;
      step();
    end
    rdo = hrdata_s;
    rsp = hresp_s;
    step();
  endtask

  initial begin
    sel_v = 1'b0; rst_n = 1'b0; hburst_v = 3'd0; hwdata_v = 32'h0;
    idle_ph();
    repeat (3) step();
    check_eq("rst_hreadyout", {31'd0, hreadyout_s}, 32'd1);
    check_eq("rst_hresp", {31'd0, hresp_s}, 32'd0);
    check_eq("rst_hrdata", hrdata_s, 32'd0);
    check_eq("rst_hreadyout_ws3", {31'd0, bus3.hreadyout}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Zero-wait write then back-to-back read of the same word.
    addr_ph(1'b1, 2'b10, 1'b1, 32'h0010_0000, 3'd2);
    step();
    check_eq("wr_dp_ready", {31'd0, hreadyout_s}, 32'd1);
    hwdata_v = 32'hDEAD_BEEF;
    addr_ph(1'b1, 2'b10, 1'b0, 32'h0010_0000, 3'd2);
    step();
    check_eq("b2b_rd_ready", {31'd0, hreadyout_s}, 32'd1);
    check_eq("b2b_rd_data", hrdata_s, 32'hDEAD_BEEF);
    check_eq("b2b_rd_resp", {31'd0, hresp_s}, 32'd0);
    idle_ph();
    step();
    check_eq("idle_hrdata_zero", hrdata_s, 32'd0);

    // Byte and halfword lanes, pipelined.
    addr_ph(1'b1, 2'b10, 1'b1, 32'h0010_0004, 3'd2);
    step();
    hwdata_v = 32'h1122_3344;
    addr_ph(1'b1, 2'b10, 1'b1, 32'h0010_0005, 3'd0);
    step();
    hwdata_v = 32'h5566_AA77;
    addr_ph(1'b1, 2'b10, 1'b1, 32'h0010_0006, 3'd1);
    step();
    hwdata_v = 32'h1234_CCDD;
    addr_ph(1'b1, 2'b10, 1'b0, 32'h0010_0004, 3'd2);
    step();
    check_eq("lane_merge", hrdata_s, 32'h1234_AA44);
    idle_ph();
    step();

    // Out-of-range read: two-cycle ERROR, htrans dropped to IDLE during ERR1.
    addr_ph(1'b1, 2'b10, 1'b0, 32'h0010_1000, 3'd2);
    step();
    idle_ph();
    check_eq("oor_err1_ready", {31'd0, hreadyout_s}, 32'd0);
    check_eq("oor_err1_resp", {31'd0, hresp_s}, 32'd1);
    check_eq("oor_err1_data", hrdata_s, 32'd0);
    step();
    check_eq("oor_err2_ready", {31'd0, hreadyout_s}, 32'd1);
    check_eq("oor_err2_resp", {31'd0, hresp_s}, 32'd1);
    check_eq("oor_err2_data", hrdata_s, 32'd0);
    step();
    check_eq("oor_after_resp", {31'd0, hresp_s}, 32'd0);

    // Misaligned word write, oversize and below-base accesses all error.
    single(1'b1, 32'h0010_0002, 3'd2, 32'hCAFE_F00D, rd, waits, resp);
    check_eq("misal_waits", waits, 32'd1);
    check_eq("misal_resp", {31'd0, resp}, 32'd1);
    single(1'b0, 32'h0010_0000, 3'd0, 32'h0, rd, waits, resp);
    single(1'b0, 32'h0010_0000, 3'd3, 32'h0, rd, waits, resp);
    check_eq("oversize_resp", {31'd0, resp}, 32'd1);
    single(1'b0, 32'h000F_FFFC, 3'd2, 32'h0, rd, waits, resp);
    check_eq("below_base_resp", {31'd0, resp}, 32'd1);
    single(1'b0, 32'h0010_0000, 3'd2, 32'h0, rd, waits, resp);
    check_eq("misal_mem_intact", rd, 32'hDEAD_BEEF);
    check_eq("ws0_rd_waits", waits, 32'd0);

    // Last byte of the window is legal.
    single(1'b1, 32'h0010_0FFF, 3'd0, 32'h5A00_0000, rd, waits, resp);
    check_eq("top_byte_resp", {31'd0, resp}, 32'd0);
    single(1'b0, 32'h0010_0FFC, 3'd2, 32'h0, rd, waits, resp);
    check_eq("top_byte_data", {24'd0, rd[31:24]}, 32'h0000_005A);

    // Unselected NONSEQ, then selected IDLE: no stall, no error, no write.
    hwdata_v = 32'hFFFF_FFFF;
    addr_ph(1'b0, 2'b10, 1'b1, 32'h0010_0000, 3'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("unsel_ready_resp", {30'd0, hreadyout_s, hresp_s}, 32'd2);
    end
    addr_ph(1'b1, 2'b00, 1'b1, 32'h0010_0000, 3'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("idle_ready_resp", {30'd0, hreadyout_s, hresp_s}, 32'd2);
    end
    idle_ph();
    single(1'b0, 32'h0010_0000, 3'd2, 32'h0, rd, waits, resp);
    check_eq("idle_mem_intact", rd, 32'hDEAD_BEEF);

    // Three-wait subordinate: preload four words.
    sel_v = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      single(1'b1, 32'h0010_0000 + 32'(4 * i), 3'd2, 32'hA000_0000 + 32'(i), rd, waits, resp);
      check_eq("ws3_wr_waits", waits, 32'd3);
    end

    // INCR4 read with a BUSY after beat 2.
    hburst_v = 3'b011;
    p = 0; dp = -1; stall = 0; done = 0;
    for (int cyc = 0; cyc < 200 && done < 5; cyc++) begin
      if (hreadyout_s === 1'b1) begin
        if (dp >= 0) begin
          check_eq($sformatf("burst_stall%0d", dp), stall, exp_st[dp]);
          check_eq($sformatf("burst_data%0d", dp), hrdata_s, exp_d[dp]);
          check_eq($sformatf("burst_resp%0d", dp), {31'd0, hresp_s}, 32'd0);
          done++;
        end
        if (p < 5) begin
          addr_ph(1'b1, ph_t[p], 1'b0, ph_a[p], 3'd2);
          dp = p;
          p++;
        end else begin
          idle_ph();
          dp = -1;
        end
        stall = 0;
      end else begin
        stall++;
      end
      if (done < 5) step();
    end
    check_eq("burst_done", done, 32'd5);
    hburst_v = 3'd0;
    idle_ph();
    step();

    // ERROR length does not depend on wait states.
    single(1'b0, 32'h0010_1000, 3'd2, 32'h0, rd, waits, resp);
    check_eq("ws3_err_waits", waits, 32'd1);
    check_eq("ws3_err_resp", {31'd0, resp}, 32'd1);
    check_eq("ws3_err_data", rd, 32'd0);

    // Reset during the second wait cycle of a write discards it.
    single(1'b1, 32'h0010_0010, 3'd2, 32'h0BAD_C0DE, rd, waits, resp);
    addr_ph(1'b1, 2'b10, 1'b1, 32'h0010_0010, 3'd2);
    step();
    idle_ph();
    hwdata_v = 32'h1234_5678;
    check_eq("rst_wait1_ready", {31'd0, hreadyout_s}, 32'd0);
    step();
    check_eq("rst_wait2_ready", {31'd0, hreadyout_s}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ready", {31'd0, hreadyout_s}, 32'd1);
    check_eq("async_rst_resp", {31'd0, hresp_s}, 32'd0);
    check_eq("async_rst_data", hrdata_s, 32'd0);
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    step();
    single(1'b0, 32'h0010_0010, 3'd2, 32'h0, rd, waits, resp);
    check_eq("rst_no_write", rd, 32'h0BAD_C0DE);
    check_eq("rst_rd_waits", waits, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
